uart_channel: RTL and testbench



---
 rtl/uart_channel.sv | 205 ++++++++++++++++++++
 tb/tb_uart_channel.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_channel.sv
// uart_channel: full-duplex 8N1 UART channel with RX/TX FIFOs; define UART_PARITY_EN for 8E1 framing
module uart_channel #(
    parameter int FIFO_AW     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] divider,
    input  logic        tx_wr,
    input  logic [7:0]  tx_data,
    input  logic        rx_rd,
    output logic [7:0]  rx_data,
    output logic [5:0]  status,
    input  logic        rxd,
    output logic        txd
);
    localparam int DEPTH = 1 << FIFO_AW;
`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    logic [15:0]      div_q, tick_cnt;
    logic             tick;
    logic [7:0]       tx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wp, tx_rp;
    logic             tx_empty, tx_full, tx_push, tx_pop, tx_end;
    state_t           tx_state, tx_next;
    logic [3:0]       tx_tc;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_sh, tx_head;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic             rxs, rx_prev, rx_mid, rx_end, rx_ok, rx_done, rx_bad;
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_AW:0] rx_wp, rx_rp;
    logic             rx_empty, rx_full, rx_push, rx_pop, rx_ovr, rx_err;
    state_t           rx_state, rx_next;
    logic [3:0]       rx_tc;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_sh;
`ifdef UART_PARITY_EN
    logic             tx_par, rx_perr;
    assign rx_ok = rxs && !rx_perr;
`else
    assign rx_ok = rxs;
`endif
    assign tick     = tick_cnt == ((div_q < 16'd2) ? 16'd0 : div_q - 16'd1);
    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = tx_wp == {~tx_rp[FIFO_AW], tx_rp[FIFO_AW-1:0]};
    assign tx_push  = tx_wr && !tx_full;
    assign tx_head  = tx_mem[tx_rp[FIFO_AW-1:0]];
    assign tx_end   = tick && tx_tc == 4'd15;
    assign rxs      = rx_sync[SYNC_STAGES-1];
    assign rx_mid   = tick && rx_tc == 4'd7;
    assign rx_end   = tick && rx_tc == 4'd15;
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = rx_wp == {~rx_rp[FIFO_AW], rx_rp[FIFO_AW-1:0]};
    assign rx_pop   = rx_rd && !rx_empty;
    assign rx_push  = rx_done && (!rx_full || rx_pop);
    assign rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];

    // Oversampling tick; a new divider is only picked up at the wrap
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            tick_cnt <= '0;
            div_q    <= divider;
        end else
            tick_cnt <= tick_cnt + 16'd1;
    end

    // FIFO storage (no reset needed, pointers define validity)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= tx_data;
        if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
    end

    // TX next state, FIFO pop and line level; STOP chains straight into START
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        txd     = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
        case (tx_state)
            IDLE: begin
                tx_pop  = tick && !tx_empty;
                tx_next = tx_pop ? START : IDLE;
            end
            START: tx_next = tx_end ? DATA : START;
`ifdef UART_PARITY_EN
            DATA: tx_next = (tx_end && tx_bit == 3'd7) ? PARITY : DATA;
            PARITY: begin
                txd     = tx_par;
                tx_next = tx_end ? STOP : PARITY;
            end
`else
            DATA: tx_next = (tx_end && tx_bit == 3'd7) ? STOP : DATA;
`endif
            STOP: begin
                tx_pop  = tx_end && !tx_empty;
                tx_next = tx_pop ? START : tx_end ? IDLE : STOP;
            end
            default: tx_next = IDLE;
        endcase
    end

    // TX state, pointers, tick/bit counters and shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_tc    <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) begin
                tx_rp  <= tx_rp + 1'b1;
                tx_sh  <= tx_head;
                tx_tc  <= '0;
                tx_bit <= '0;
            end else if (tick && tx_state != IDLE) begin
                tx_tc <= tx_tc + 4'd1;
                if (tx_end && tx_state == DATA) begin
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= tx_bit + 3'd1;
                end
            end
        end
    end

`ifdef UART_PARITY_EN
    // Parity bits: TX computed at load, RX compared at the parity bit centre
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_par  <= 1'b0;
            rx_perr <= 1'b0;
        end else begin
            if (tx_pop) tx_par <= ^tx_head;
            if (rx_end && rx_state == PARITY) rx_perr <= rxs != ^rx_sh;
        end
    end
`endif

    // rxd synchroniser and edge history
    always_ff @(posedge clk) begin
        rx_sync <= reset ? '1 : {rx_sync[SYNC_STAGES-2:0], rxd};
        rx_prev <= reset ? 1'b1 : rxs;
    end

    // RX next state; a bad stop needs rxd high again before a new falling edge can arm
    always_comb begin
        rx_next = rx_state;
        rx_done = 1'b0;
        rx_bad  = 1'b0;
        case (rx_state)
            IDLE: rx_next = (rx_prev && !rxs) ? START : IDLE;
            START: rx_next = rx_mid ? (rxs ? IDLE : DATA) : START;
`ifdef UART_PARITY_EN
            DATA: rx_next = (rx_end && rx_bit == 3'd7) ? PARITY : DATA;
            PARITY: rx_next = rx_end ? STOP : PARITY;
`else
            DATA: rx_next = (rx_end && rx_bit == 3'd7) ? STOP : DATA;
`endif
            STOP: begin
                rx_done = rx_end && rx_ok;
                rx_bad  = rx_end && !rx_ok;
                rx_next = rx_end ? IDLE : STOP;
            end
            default: rx_next = IDLE;
        endcase
    end

    // RX state, counters, shifter, pointers and sticky flags (set beats clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_tc    <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_ovr   <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_tc    <= (rx_state == IDLE || (rx_mid && rx_state == START)) ? 4'd0 :
                        tick ? rx_tc + 4'd1 : rx_tc;
            if (rx_end && rx_state == DATA) begin
                rx_sh  <= {rxs, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_ovr <= (rx_done && rx_full && !rx_pop) || (rx_ovr && !rx_rd);
            rx_err <= rx_bad || (rx_err && !rx_rd);
        end
    end

    // Registered status word
    always_ff @(posedge clk) begin
        status <= reset ? 6'b100000 :
                  {tx_empty && tx_state == IDLE, tx_full, rx_err, rx_ovr, rx_full, !rx_empty};
    end
endmodule

// File: tb/tb_uart_channel.sv
// tb_uart_channel: randomized scoreboard bench for uart_channel (RX driver/reader, TX line decoder)
module tb_uart_channel;
    localparam int DIV = 2;
    localparam int BT  = 16 * DIV;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB = 10 + PB;

    logic        clk = 1'b0;
    logic        reset, tx_wr, rx_rd, rxd, txd;
    logic [15:0] divider;
    logic [7:0]  tx_data, rx_data;
    logic [5:0]  status;

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] tx_exp[$], rx_exp[$];
    bit tx_mon_en = 0, tx_burst = 0, rd_en = 0, clr_req = 0;
    int last_t0 = -1, rd_cnt = 0;

    uart_channel dut (
        .clk(clk), .reset(reset), .divider(divider), .tx_wr(tx_wr), .tx_data(tx_data),
        .rx_rd(rx_rd), .rx_data(rx_data), .status(status), .rxd(rxd), .txd(txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] b);
        tx_wr = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BT) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rxd = ^b;
        repeat (BT) @(negedge clk);
`endif
        rxd = stop;
        repeat (BT) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic drain(input bit is_tx, input int budget, input string name);
        while ((is_tx ? tx_exp.size() : rx_exp.size()) != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, is_tx ? tx_exp.size() : rx_exp.size(), 0);
        if (is_tx) tx_exp.delete();
        else rx_exp.delete();
    endtask

    task automatic wait_txd_low(input int budget, input string name);
        while (txd !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, txd, 0);
    endtask

    // TX line decoder: samples every bit centre and scores frames against the expected queue
    initial begin
        logic [FB-1:0] f;
        int t0;
        forever begin
            @(negedge clk);
            if (tx_mon_en && txd === 1'b0) begin
                t0 = cyc;
                for (int k = 0; k < FB; k++) begin
                    repeat (k == 0 ? BT / 2 : BT) @(negedge clk);
                    f[k] = txd;
                end
                check("tx_start_bit", f[0], 0);
                check("tx_stop_bit", f[FB-1], 1);
`ifdef UART_PARITY_EN
                check("tx_parity", f[9], ^f[8:1]);
`endif
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=%0h required=none", f[8:1]);
                end else
                    check("tx_byte", f[8:1], tx_exp.pop_front());
                if (tx_burst && last_t0 >= 0) check("tx_gap", t0 - last_t0, FB * BT);
                last_t0 = t0;
            end
        end
    end

    // RX reader: pops the DUT FIFO whenever data is available and scores it
    initial begin
        rx_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (clr_req) begin
                rx_rd = 1'b1;
                @(negedge clk);
                rx_rd = 1'b0;
                clr_req = 0;
                repeat (2) @(negedge clk);
            end else if (rd_en && status[0]) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
                end else
                    check("rx_data", rx_data, rx_exp.pop_front());
                rx_rd = 1'b1;
                @(negedge clk);
                rx_rd = 1'b0;
                rd_cnt++;
                repeat (2) @(negedge clk);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, budget;
        logic [7:0] b;
        rxd = 1'b1;
        tx_wr = 1'b0;
        tx_data = '0;
        divider = 16'(DIV);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_status", status, 6'b100000);
            check("idle_txd", txd, 1);
            check("idle_rx_data", rx_data, 0);
        end
        // single known TX byte
        tx_mon_en = 1;
        tx_exp.push_back(8'hA5);
        tx_write(8'hA5);
        repeat (5) @(negedge clk);
        check("tx_busy", status[5], 0);
        drain(1, FB * BT + 100, "tx_a5_drain");
        repeat (BT) @(negedge clk);
        check("tx_idle_after", status[5], 1);
        // single known RX byte
        rd_en = 1;
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        drain(0, 200, "rx_3c_drain");
        repeat (4) @(negedge clk);
        check("rx_avail_after_rd", status[0], 0);
        check("rx_data_after_rd", rx_data, 0);
        // random full-duplex traffic
        fork
            for (int i = 0; i < 8; i++) begin
                logic [7:0] r;
                r = 8'($urandom);
                rx_exp.push_back(r);
                send_rx(r, 1'b1);
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
            for (int i = 0; i < 8; i++) begin
                logic [7:0] t;
                t = 8'($urandom);
                tx_exp.push_back(t);
                tx_write(t);
                repeat ($urandom_range(0, 400)) @(negedge clk);
            end
        join
        drain(0, 300, "rx_rand_drain");
        drain(1, 9 * FB * BT, "tx_rand_drain");
        // RX overflow: 17 frames with no reads
        rd_en = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_exp.push_back(8'(i));
            send_rx(8'(i), 1'b1);
        end
        repeat (10) @(negedge clk);
        check("ovf_full", status[1], 1);
        check("ovf_overrun", status[2], 1);
        check("ovf_avail", status[0], 1);
        check("ovf_head", rx_data, 0);
        base = rd_cnt;
        rd_en = 1;
        budget = 100;
        while (rd_cnt == base && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (2) @(negedge clk);
        check("ovf_clear", status[2], 0);
        drain(0, 200, "ovf_drain");
        repeat (4) @(negedge clk);
        check("ovf_read_count", rd_cnt - base, 16);
        check("ovf_empty", status[0], 0);
        // bad stop bit then a short glitch
        send_rx(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        rxd = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (FB * BT + 50) @(negedge clk);
        check("frame_err", status[3], 1);
        check("frame_no_push", status[0], 0);
        check("frame_rx_data", rx_data, 0);
        clr_req = 1;
        repeat (6) @(negedge clk);
        check("frame_err_clear", status[3], 0);
        // TX burst: one byte in flight, 20 back-to-back writes
        tx_burst = 1;
        last_t0 = -1;
        b = 8'($urandom);
        tx_exp.push_back(b);
        tx_write(b);
        wait_txd_low(100, "burst_first_start");
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            if (i < 16) tx_exp.push_back(b);
            tx_write(b);
        end
        repeat (2) @(negedge clk);
        check("burst_tx_full", status[4], 1);
        drain(1, 18 * FB * BT + 200, "burst_drain");
        tx_burst = 0;
        repeat (BT) @(negedge clk);
        check("burst_idle", status[5], 1);
        // reset in the middle of a frame with more bytes queued
        tx_mon_en = 0;
        for (int i = 0; i < 4; i++) tx_write(8'($urandom));
        wait_txd_low(100, "rst_frame_start");
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_status", status, 6'b100000);
        check("rst_rx_data", rx_data, 0);
        reset = 1'b0;
        for (int i = 0; i < 2 * FB * BT; i++) begin
            @(negedge clk);
            check("post_rst_txd", txd, 1);
            check("post_rst_status", status, 6'b100000);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
